// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: word width, instruction field
// slices, opcode/T-field encodings, the bubble word and the fetch FSM states.
package fetch_unit_pkg;

    localparam int WORD = 16;

    // Instruction field slices
    localparam int OP_HI = 15;
    localparam int OP_LO = 12;
    localparam int T_HI  = 3;
    localparam int T_LO  = 0;

    // Encodings
    localparam logic [3:0]      OPNOARG   = 4'h0;
    localparam logic [3:0]      T_TRAP    = 4'h0;
    localparam logic [WORD-1:0] NOPWORD_C = 16'h000F;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    // A trap is the noarg opcode with the trap T-field.
    function automatic logic is_trap(input logic [WORD-1:0] w);
        return (w[OP_HI:OP_LO] == OPNOARG) && (w[T_HI:T_LO] == T_TRAP);
    endfunction

endpackage

// File: rtl/fetch_unit_call_stack.sv
// Hardware call stack: a CALLDEPTH x WIDTH shift register whose top is
// entry 0, with a saturating depth counter and sticky overflow/underflow flags.
module call_stack
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH     = WORD,
    parameter int CALLDEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               din,
    output logic [WIDTH-1:0]               top,
    output logic [$clog2(CALLDEPTH+1)-1:0] depth,
    output logic                           ovf,
    output logic                           unf
);

    localparam int DW = $clog2(CALLDEPTH + 1);

    logic [WIDTH-1:0] entry [CALLDEPTH];

    assign top = entry[0];

    // Shift entries down on push, up on pop (zero fills the vacated bottom);
    // pop wins if both arrive together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < CALLDEPTH; i++) entry[i] <= '0;
            depth <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (pop) begin
            for (int i = 0; i < CALLDEPTH - 1; i++) entry[i] <= entry[i+1];
            entry[CALLDEPTH-1] <= '0;
            if (depth == '0) unf   <= 1'b1;
            else             depth <= depth - DW'(1);
        end else if (push) begin
            entry[0] <= din;
            for (int i = 1; i < CALLDEPTH; i++) entry[i] <= entry[i-1];
            if (depth == DW'(CALLDEPTH)) ovf   <= 1'b1;
            else                         depth <= depth + DW'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and call stack, drives the
// instruction-memory address, registers fetched words into ir, applies
// redirects from execute with a one-bubble penalty and halts after a trap.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int               WIDTH     = WORD,
    parameter int               CALLDEPTH = 4,
    parameter logic [WIDTH-1:0] RESETPC   = 16'h0000,
    parameter logic [WIDTH-1:0] NOPWORD   = NOPWORD_C
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_data,
    output logic [WIDTH-1:0] ir,
    output logic             irvalid,
    output logic [WIDTH-1:0] irpc,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             call,
    input  logic [WIDTH-1:0] call_target,
    input  logic [WIDTH-1:0] call_link,
    input  logic             ret,
    output logic             halted,
    output logic             stack_ovf,
    output logic             stack_unf
);

    localparam int DW = $clog2(CALLDEPTH + 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] stk_top;
    logic [DW-1:0]    stk_depth;
    logic [WIDTH-1:0] ret_pc;
    logic             any_redir;
    logic             fetch_trap;

    assign any_redir  = ret | call | redirect;
    assign fetch_trap = is_trap(imem_data);
    // An empty stack returns 0 regardless of stale contents.
    assign ret_pc     = (stk_depth == '0) ? '0 : stk_top;
    assign imem_addr  = pc;

    call_stack #(
        .WIDTH     (WIDTH),
        .CALLDEPTH (CALLDEPTH)
    ) u_call_stack (
        .clk   (clk),
        .reset (reset),
        .push  (call & ~ret),
        .pop   (ret),
        .din   (call_link),
        .top   (stk_top),
        .depth (stk_depth),
        .ovf   (stack_ovf),
        .unf   (stack_unf)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) state <= RUN;
        else        state <= state_nxt;
    end

    // FSM next state: any redirect resumes fetching, an unstalled trap fetch halts
    always_comb begin
        state_nxt = state;
        if (any_redir)
            state_nxt = RUN;
        else if (state == RUN && !stall && fetch_trap)
            state_nxt = HALTED;
    end

    // FSM outputs
    always_comb begin
        halted = (state == HALTED);
    end

    // PC and IR registers: redirects insert a bubble, RUN fetches, HALTED drains NOPs
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc      <= RESETPC;
            ir      <= NOPWORD;
            irvalid <= 1'b0;
            irpc    <= '0;
        end else if (any_redir) begin
            if (ret)       pc <= ret_pc;
            else if (call) pc <= call_target;
            else           pc <= redirect_pc;
            ir      <= NOPWORD;
            irvalid <= 1'b0;
        end else if (!stall) begin
            if (state == RUN) begin
                ir      <= imem_data;
                irpc    <= pc;
                irvalid <= 1'b1;
                if (!fetch_trap) pc <= pc + WIDTH'(1);
            end else begin
                ir      <= NOPWORD;
                irvalid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage sitting directly upstream of the decoder. It owns the program counter and the 4-deep hardware call stack, and drives the instruction-memory address. It registers each fetched word into `ir` for decode, and applies redirects (jump/jumpf, call, ret) fed back from later pipeline stages. It inserts NOP bubbles on redirects and stops fetching after a `trap` is issued.

## Interface
- `WIDTH`, 16, instruction/address width
- `CALLDEPTH`, 4, call-stack entries (4 × 16 = 64 bits, matching the processor's call-stack size)
- `RESETPC`, 16'h0000, PC value after reset
- `NOPWORD`, 16'h000F, bubble word (noarg opcode, T=F → `OPnop`)
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-low reset
- `stall`  in  1  downstream hold request
- `imem_addr`  out  16  instruction-memory address; combinational, equals `pc`
- `imem_data`  in  16  instruction word, same-cycle asynchronous read of `imem_addr`
- `ir`  out  16  registered instruction to decode
- `irvalid`  out  1  `ir` holds a real instruction (0 = bubble)
- `irpc`  out  16  address `ir` was fetched from
- `redirect`  in  1  taken jump/jumpf from execute
- `redirect_pc`  in  16  jump target
- `call`  in  1  call resolved in execute
- `call_target`  in  16  call target
- `call_link`  in  16  return address to push (caller PC + 1)
- `ret`  in  1  return resolved in execute
- `halted`  out  1  fetch stopped after a trap
- `stack_ovf`  out  1  sticky: push issued while 4 entries were valid
- `stack_unf`  out  1  sticky: pop issued while 0 entries were valid

## Operation
- **States:** RUN and HALTED.
- **Reset** (`reset`=0 at a clock edge):
  - `pc`=RESETPC, `ir`=NOPWORD, `irvalid`=0, `irpc`=0.
  - Call-stack entries = 0, depth = 0.
  - `halted`=0, `stack_ovf`=0, `stack_unf`=0; state = RUN.
  - Reset overrides all other inputs.
- **Event priority** at each edge: reset > `ret` > `call` > `redirect` > state/stall handling. `ret`/`call`/`redirect` are mutually exclusive by construction; the priority only resolves protocol violations.
- **`ret`:**
  - `pc` ← top entry; the stack shifts up and a 0 enters the bottom.
  - depth decrements and saturates at 0. Popping at depth 0 yields 0 and sets `stack_unf`.
- **`call`:**
  - `call_link` is pushed at the top and the bottom entry is discarded; `pc` ← `call_target`.
  - depth increments and saturates at 4. Pushing at depth 4 sets `stack_ovf`.
- **`redirect`:** `pc` ← `redirect_pc`.
- **Any of `ret`/`call`/`redirect`:**
  - `ir` ← NOPWORD, `irvalid` ← 0.
  - State ← RUN. A redirect from an older instruction cancels HALTED; downstream squashes the already-issued trap.
  - Stall is ignored for this edge.
- **RUN, `stall`=1, no redirect:** `pc`, `ir`, `irvalid`, `irpc` all held.
- **RUN, `stall`=0:**
  - `ir` ← `imem_data`, `irpc` ← `pc`, `irvalid` ← 1.
  - If `imem_data` is a trap (bits[15:12]=0 and bits[3:0]=0), state ← HALTED and `pc` is held. Otherwise `pc` ← `pc`+1, wrapping FFFF→0000.
- **HALTED:**
  - `pc` is frozen and `halted`=1.
  - Unstalled edges load `ir` ← NOPWORD, `irvalid` ← 0.
  - Stalled edges hold `ir`.

## Timing
- Fetch latency is 1 cycle: the word at `pc` in cycle N appears on `ir` in cycle N+1.
- Redirect penalty is exactly 1 bubble:
  - redirect sampled at edge N;
  - `imem_addr`=target during N+1;
  - `ir`=mem[target] after edge N+1.
- Sticky flags assert on the edge of the offending push/pop and clear only on reset.
- `halted` rises on the edge that loads the trap into `ir`.
- `imem_addr` has no register; it changes right after the edge that updates `pc`.

## Structure
- Shared package/header holds:
  - WORD width;
  - the opcode field slice [15:12] and T field slice [3:0];
  - the `OPnoarg` and trap T-field encodings;
  - NOPWORD.
- The call stack is a natural sub-module `call_stack`:
  - ports: `push`, `pop`, `din`, `top`, `depth`, `ovf`, `unf`;
  - CALLDEPTH×WIDTH shift register with a saturating depth counter.
- Everything else (state, PC, IR registers) is inline.

## Test plan
- Reset, then run 3 unstalled cycles with mem[0..2]=1123,2345,3456 → `ir` = 1123, 2345, 3456 on consecutive cycles; `irpc` = 0, 1, 2; `irvalid`=1.
- `stall`=1 for 2 cycles while `ir`=2345 → `ir`, `irpc`, `pc` unchanged; resumes with 3456.
- `redirect`=1, `redirect_pc`=0040 at pc=5 → next `ir`=000F with `irvalid`=0, then `ir`=mem[0040] with `irpc`=0040.
- 5 calls (links 0011..0015) then 5 rets:
  - `stack_ovf`=1 after the 5th call;
  - rets return to 0015, 0014, 0013, 0012, then 0000;
  - `stack_unf`=1 on the 5th ret.
- mem[3]=0000 (trap):
  - `ir`=0000, then `halted`=1 and `pc` stays 3 with NOP bubbles;
  - `redirect` to 0008 → `halted`=0 and fetch resumes at 0008.
- `reset`=0 asserted mid-run with depth 2, `stack_ovf`=1 → next edge: `pc`=0, depth 0, flags 0, `ir`=000F.
